// File: rtl/ysyx_22050243_mem_arbiter.sv
// Shares the core memory port between IFU and LSU.
// Fixed LSU-first priority with an IFU starvation guard; one transaction in flight.
module ysyx_22050243_mem_arbiter #(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64,
  parameter int MAX_LSU_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                busy
);

  localparam int          MASK_W  = DATA_W / 8;
  localparam logic [3:0]  MAX_CNT = 4'(MAX_LSU_BURST);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t              state_reg, state_next;
  logic                owner_lsu_reg, owner_lsu_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                wen_reg, wen_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [MASK_W-1:0]   wmask_reg, wmask_next;

  logic lsu_win;
  logic ifu_win;
  logic rsp_hit;

  // LSU loses only when the IFU has already waited out a full burst.
  assign lsu_win = lsu_req_valid && !(ifu_req_valid && cnt_reg == MAX_CNT);
  assign ifu_win = ifu_req_valid && !lsu_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      owner_lsu_reg <= 1'b0;
      cnt_reg       <= 4'd0;
      addr_reg      <= '0;
      wen_reg       <= 1'b0;
      wdata_reg     <= '0;
      wmask_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      owner_lsu_reg <= owner_lsu_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      wen_reg       <= wen_next;
      wdata_reg     <= wdata_next;
      wmask_reg     <= wmask_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_lsu_next = owner_lsu_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    wen_next       = wen_reg;
    wdata_next     = wdata_reg;
    wmask_next     = wmask_reg;
    lsu_req_ready  = 1'b0;
    ifu_req_ready  = 1'b0;
    case (state_reg)
      IDLE: begin
        // Readies are gated by rst_n so nothing is granted while reset is held.
        lsu_req_ready = rst_n && lsu_win;
        ifu_req_ready = rst_n && ifu_win;
        if (lsu_win) begin
          state_next     = REQ;
          owner_lsu_next = 1'b1;
          addr_next      = lsu_addr;
          wen_next       = lsu_wen;
          wdata_next     = lsu_wdata;
          wmask_next     = lsu_wmask;
          if (!ifu_req_valid)
            cnt_next = 4'd0;
          else if (cnt_reg != MAX_CNT)
            cnt_next = cnt_reg + 4'd1;
        end else if (ifu_win) begin
          state_next     = REQ;
          owner_lsu_next = 1'b0;
          addr_next      = ifu_addr;
          wen_next       = 1'b0;
          wdata_next     = '0;
          wmask_next     = '0;
          cnt_next       = 4'd0;
        end
      end
      REQ: begin
        if (mem_req_ready)
          state_next = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Responses pass straight through to the owner; strays outside WAIT are dropped.
  assign rsp_hit       = (state_reg == WAIT) && mem_rsp_valid;
  assign lsu_rsp_valid = rsp_hit && owner_lsu_reg;
  assign ifu_rsp_valid = rsp_hit && !owner_lsu_reg;
  assign lsu_rsp_data  = lsu_rsp_valid ? mem_rsp_data : '0;
  assign ifu_rsp_data  = ifu_rsp_valid ? mem_rsp_data : '0;

  assign mem_req_valid = (state_reg == REQ);
  assign mem_addr      = addr_reg;
  assign mem_wen       = wen_reg;
  assign mem_wdata     = wdata_reg;
  assign mem_wmask     = wmask_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_ysyx_22050243_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: transaction-level model
// compared every cycle, plus directed literal checks for the key scenarios.
module tb_ysyx_22050243_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ifu_req_valid = 0, ifu_req_ready;
  logic [AW-1:0] ifu_addr = '0;
  logic          ifu_rsp_valid;
  logic [DW-1:0] ifu_rsp_data;
  logic          lsu_req_valid = 0, lsu_req_ready;
  logic [AW-1:0] lsu_addr = '0;
  logic          lsu_wen = 0;
  logic [DW-1:0] lsu_wdata = '0;
  logic [MW-1:0] lsu_wmask = '0;
  logic          lsu_rsp_valid;
  logic [DW-1:0] lsu_rsp_data;
  logic          mem_req_valid, mem_req_ready = 0;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_rsp_valid = 0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic          busy;

  ysyx_22050243_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LSU_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending transaction record plus the grant count.
  bit            m_busy, m_issued, m_owner_lsu;
  int            m_cnt;
  logic [AW-1:0] m_addr;
  logic          m_wen;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_wmask;
  bit            e_lw, e_iw;
  bit            auto_mem = 0;
  int            wait_left = 0;
  byte           grant_q[$];

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_owner_lsu = 0; m_cnt = 0;
    m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
  endtask

  task automatic drive_mem();
    if (!auto_mem) return;
    mem_rsp_data = {$urandom, $urandom};
    mem_req_ready = ($urandom_range(0, 3) != 0);
    if (m_busy && m_issued) begin
      if (wait_left == 0) mem_rsp_valid = 1;
      else begin
        mem_rsp_valid = 0;
        wait_left--;
      end
    end else begin
      mem_rsp_valid = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic step();
    bit e_rsp;
    drive_mem();
    @(negedge clk);
    if (lsu_req_ready) grant_q.push_back(8'h4C);
    if (ifu_req_ready) grant_q.push_back(8'h49);
    if (!rst_n) begin
      e_lw = 0; e_iw = 0;
      chk("rst_ifu_req_ready", ifu_req_ready, 0);
      chk("rst_lsu_req_ready", lsu_req_ready, 0);
      chk("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
      chk("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
      chk("rst_ifu_rsp_data", ifu_rsp_data, 0);
      chk("rst_lsu_rsp_data", lsu_rsp_data, 0);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wmask", {56'd0, mem_wmask}, 0);
      chk("rst_busy", busy, 0);
    end else begin
      e_lw  = !m_busy && lsu_req_valid && !(ifu_req_valid && m_cnt == MAXB);
      e_iw  = !m_busy && ifu_req_valid && !e_lw;
      e_rsp = m_busy && m_issued && mem_rsp_valid;
      chk("lsu_req_ready", lsu_req_ready, e_lw);
      chk("ifu_req_ready", ifu_req_ready, e_iw);
      chk("mem_req_valid", mem_req_valid, m_busy && !m_issued);
      chk("lsu_rsp_valid", lsu_rsp_valid, e_rsp && m_owner_lsu);
      chk("ifu_rsp_valid", ifu_rsp_valid, e_rsp && !m_owner_lsu);
      chk("lsu_rsp_data", lsu_rsp_data, (e_rsp && m_owner_lsu) ? mem_rsp_data : 64'd0);
      chk("ifu_rsp_data", ifu_rsp_data, (e_rsp && !m_owner_lsu) ? mem_rsp_data : 64'd0);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wen", mem_wen, m_wen);
      chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, m_wmask});
      if (m_wen) chk("mem_wdata", mem_wdata, m_wdata);
      chk("busy", busy, m_busy);
    end
  endtask

  task automatic fin();
    if (!rst_n) model_reset();
    else if (!m_busy) begin
      if (e_lw) begin
        m_busy = 1; m_issued = 0; m_owner_lsu = 1;
        m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
        m_cnt = ifu_req_valid ? ((m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1) : 0;
      end else if (e_iw) begin
        m_busy = 1; m_issued = 0; m_owner_lsu = 0;
        m_addr = ifu_addr; m_wen = 0; m_wmask = '0;
        m_cnt = 0;
      end
    end else if (!m_issued) begin
      if (mem_req_ready) begin
        m_issued = 1;
        wait_left = $urandom_range(0, 3);
      end
    end else if (mem_rsp_valid) begin
      m_busy = 0; m_issued = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    step();
    fin();
  endtask

  task automatic rand_req();
    ifu_req_valid = ($urandom_range(0, 9) < 7);
    ifu_addr      = {32'h0, 32'h80000000 | ($urandom & 32'h0000fffc)};
    lsu_req_valid = ($urandom_range(0, 9) < 6);
    lsu_addr      = {$urandom, $urandom};
    lsu_wen       = $urandom_range(0, 1);
    lsu_wdata     = {$urandom, $urandom};
    lsu_wmask     = 8'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string exp_order;
    logic [AW-1:0] held_addr;
    model_reset();
    // Reset held with both requesters asserting: every output must stay 0.
    ifu_req_valid = 1; lsu_req_valid = 1; ifu_addr = 64'h1234; lsu_addr = 64'h5678;
    cyc(); cyc();
    rst_n = 1;
    lsu_req_valid = 0;

    // Scenario 1: single IFU fetch.
    ifu_req_valid = 1; ifu_addr = 64'h80000000; mem_req_ready = 1;
    step(); chk("t1_ifu_ready", ifu_req_ready, 1); chk("t1_lsu_ready", lsu_req_ready, 0); fin();
    ifu_req_valid = 0;
    step(); chk("t1_mem_req_valid", mem_req_valid, 1); chk("t1_mem_wen", mem_wen, 0);
    chk("t1_mem_wmask", {56'd0, mem_wmask}, 0); chk("t1_mem_addr", mem_addr, 64'h80000000); fin();
    mem_rsp_valid = 1; mem_rsp_data = 64'h00000013_00100093;
    step(); chk("t1_ifu_rsp_valid", ifu_rsp_valid, 1);
    chk("t1_ifu_rsp_data", ifu_rsp_data, 64'h00000013_00100093); chk("t1_lsu_rsp_valid", lsu_rsp_valid, 0); fin();
    mem_rsp_valid = 0;

    // Scenario 2: simultaneous requests, LSU write first then IFU.
    ifu_req_valid = 1; ifu_addr = 64'h80000004;
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 64'h80001000; lsu_wdata = 64'hDEADBEEF; lsu_wmask = 8'h0F;
    step(); chk("t2_lsu_ready", lsu_req_ready, 1); chk("t2_ifu_ready", ifu_req_ready, 0); fin();
    lsu_req_valid = 0;
    step(); chk("t2_mem_addr", mem_addr, 64'h80001000); chk("t2_mem_wen", mem_wen, 1);
    chk("t2_mem_wdata", mem_wdata, 64'hDEADBEEF); chk("t2_mem_wmask", {56'd0, mem_wmask}, 64'h0F);
    chk("t2_ifu_ready_busy", ifu_req_ready, 0); fin();
    mem_rsp_valid = 1; mem_rsp_data = 64'h0;
    step(); chk("t2_lsu_rsp_valid", lsu_rsp_valid, 1); chk("t2_ifu_rsp_valid", ifu_rsp_valid, 0); fin();
    mem_rsp_valid = 0;
    step(); chk("t2_ifu_ready_next", ifu_req_ready, 1); fin();
    ifu_req_valid = 0;
    cyc();
    mem_rsp_valid = 1; mem_rsp_data = 64'h1111;
    cyc();
    mem_rsp_valid = 0;

    // Scenario 4: memory stalls for 5 cycles in REQ.
    ifu_req_valid = 1; ifu_addr = 64'h80000200; mem_req_ready = 0;
    cyc();
    lsu_req_valid = 1; lsu_wen = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_mem_req_valid", mem_req_valid, 1); chk("t4_mem_addr", mem_addr, 64'h80000200);
      chk("t4_mem_wen", mem_wen, 0); chk("t4_mem_wmask", {56'd0, mem_wmask}, 0);
      chk("t4_busy", busy, 1); chk("t4_ifu_ready", ifu_req_ready, 0); chk("t4_lsu_ready", lsu_req_ready, 0);
      fin();
    end
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1;
    cyc();
    mem_rsp_valid = 1; mem_rsp_data = 64'hA5A5;
    step(); chk("t4_ifu_rsp_valid", ifu_rsp_valid, 1); fin();
    mem_rsp_valid = 0;

    // Scenario 5: stray responses in IDLE and REQ are ignored.
    mem_rsp_valid = 1; mem_rsp_data = 64'hBAD;
    step(); chk("t5_idle_ifu_rsp", ifu_rsp_valid, 0); chk("t5_idle_lsu_rsp", lsu_rsp_valid, 0);
    chk("t5_idle_busy", busy, 0); fin();
    mem_rsp_valid = 0; lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 64'h80002000;
    cyc();
    lsu_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 1;
    step(); chk("t5_req_lsu_rsp", lsu_rsp_valid, 0); chk("t5_req_ifu_rsp", ifu_rsp_valid, 0); fin();
    mem_rsp_valid = 0; mem_req_ready = 1;
    step(); chk("t5_still_req", mem_req_valid, 1); fin();
    mem_rsp_valid = 1; mem_rsp_data = 64'h77;
    step(); chk("t5_lsu_rsp", lsu_rsp_valid, 1); chk("t5_lsu_data", lsu_rsp_data, 64'h77); fin();
    mem_rsp_valid = 0;

    // Scenario 3: both held valid -> grant order LLLLILLLLI.
    auto_mem = 1;
    grant_q.delete();
    ifu_req_valid = 1; lsu_req_valid = 1; lsu_wen = 0;
    for (int i = 0; i < 300 && grant_q.size() < 10; i++) cyc();
    chk("t3_grant_count", 64'(grant_q.size() >= 10 ? 10 : grant_q.size()), 64'd10);
    exp_order = "LLLLILLLLI";
    for (int i = 0; i < 10 && i < grant_q.size(); i++)
      chk($sformatf("t3_grant_%0d", i), 64'(grant_q[i]), 64'(exp_order.getc(i)));

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rand_req();
      cyc();
    end

    // Scenario 6: async reset mid-WAIT, response afterwards ignored.
    auto_mem = 0;
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1; mem_rsp_valid = 0;
    for (int i = 0; i < 20 && (busy || m_busy); i++) begin
      mem_rsp_valid = m_issued;
      cyc();
    end
    mem_rsp_valid = 0;
    chk("t6_idle_before", busy, 0);
    ifu_req_valid = 1; ifu_addr = 64'h80000300;
    cyc();
    ifu_req_valid = 0;
    cyc();
    held_addr = mem_addr;
    chk("t6_in_wait_addr", held_addr, 64'h80000300);
    chk("t6_in_wait_busy", busy, 1);
    ifu_req_valid = 1;
    #2 rst_n = 0;
    #1;
    chk("t6_async_busy", busy, 0); chk("t6_async_mem_addr", mem_addr, 0);
    chk("t6_async_mem_req_valid", mem_req_valid, 0); chk("t6_async_ifu_ready", ifu_req_ready, 0);
    model_reset();
    ifu_req_valid = 0;
    cyc();
    rst_n = 1;
    mem_rsp_valid = 1; mem_rsp_data = 64'hDEAD;
    step(); chk("t6_ignored_rsp", ifu_rsp_valid, 0); chk("t6_ignored_busy", busy, 0); fin();
    mem_rsp_valid = 0;
    ifu_req_valid = 1; ifu_addr = 64'h80000400;
    step(); chk("t6_new_ready", ifu_req_ready, 1); fin();
    ifu_req_valid = 0;
    step(); chk("t6_new_addr", mem_addr, 64'h80000400); fin();
    mem_rsp_valid = 1; mem_rsp_data = 64'h00000013_00000013;
    step(); chk("t6_new_rsp", ifu_rsp_data, 64'h00000013_00000013); fin();
    mem_rsp_valid = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
